// File: rtl/led_status_ctrl.sv
// Single-LED status controller: latched fault blink code > SD-busy fast blink > idle heartbeat.
// Build option LED_HEARTBEAT_EN: when defined, idle shows a heartbeat; otherwise idle keeps the LED off.
module led_status_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int HB_HALF   = 50,
    parameter int FAST_HALF = 10,
    parameter int PULSE_ON  = 20,
    parameter int PULSE_OFF = 20,
    parameter int CODE_GAP  = 100
) (
    input  logic       clk_input,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fault_valid,
    input  logic [2:0] fault_code,
    input  logic       fault_clr,
    input  logic       sd_busy,
    output logic       LED,
    output logic [1:0] mode,
    output logic       fault_active
);
    localparam int MAX_A     = (HB_HALF > FAST_HALF) ? HB_HALF : FAST_HALF;
    localparam int MAX_B     = (PULSE_ON > PULSE_OFF) ? PULSE_ON : PULSE_OFF;
    localparam int MAX_C     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_TICKS = (MAX_C > CODE_GAP) ? MAX_C : CODE_GAP;
    localparam int PW        = $clog2(TICK_DIV);
    localparam int HW        = $clog2(MAX_TICKS) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {MODE_OFF, MODE_HEART, MODE_SDBUSY, MODE_FAULT} mode_e;
    typedef enum logic [1:0] {F_ON, F_OFF, F_GAP} fstate_e;

`ifdef LED_HEARTBEAT_EN
    localparam mode_e IDLE_MODE = MODE_HEART;
`else
    localparam mode_e IDLE_MODE = MODE_OFF;
`endif

    mode_e          mode_q, mode_d;
    fstate_e        fstate_q, fstate_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [HW-1:0]  phase_q, phase_d;
    logic [2:0]     n_q, n_d;
    logic [2:0]     code_q, code_d;
    logic           fault_active_q, fault_active_d;
    logic           led_q, led_d;
    logic           tick;
    logic           ival_end;
    logic [HW-1:0]  ival;

    always_comb begin
        fault_active_d = fault_active_q;
        code_d         = code_q;
        mode_d         = IDLE_MODE;
        presc_d        = presc_q;
        phase_d        = phase_q;
        fstate_d       = fstate_q;
        n_d            = n_q;
        led_d          = led_q;
        ival           = HW'(1);

        // Clear beats a simultaneous report; first latched fault wins over later ones.
        if (fault_clr) begin
            fault_active_d = 1'b0;
            code_d         = 3'd0;
        end else if (fault_valid && (fault_code != 3'd0) && !fault_active_q) begin
            fault_active_d = 1'b1;
            code_d         = fault_code;
        end

        if (!enable)             mode_d = MODE_OFF;
        else if (fault_active_d) mode_d = MODE_FAULT;
        else if (sd_busy)        mode_d = MODE_SDBUSY;
        else                     mode_d = IDLE_MODE;

        case (mode_q)
`ifdef LED_HEARTBEAT_EN
            MODE_HEART:  ival = HW'(HB_HALF);
`endif
            MODE_SDBUSY: ival = HW'(FAST_HALF);
            MODE_FAULT: begin
                case (fstate_q)
                    F_ON:    ival = HW'(PULSE_ON);
                    F_OFF:   ival = HW'(PULSE_OFF);
                    default: ival = HW'(CODE_GAP);
                endcase
            end
            default: ival = HW'(1);
        endcase

        tick     = (presc_q == PRESC_LAST);
        ival_end = tick && (phase_q == ival - 1'b1);

        if (mode_d != mode_q) begin
            // Every mode starts its pattern from scratch on the edge that registers it.
            presc_d  = '0;
            phase_d  = '0;
            fstate_d = F_ON;
            n_d      = 3'd0;
            led_d    = (mode_d != MODE_OFF);
        end else if (mode_q == MODE_OFF) begin
            presc_d  = '0;
            phase_d  = '0;
            fstate_d = F_ON;
            n_d      = 3'd0;
            led_d    = 1'b0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) phase_d = ival_end ? '0 : phase_q + 1'b1;
            if (ival_end) begin
                if (mode_q == MODE_FAULT) begin
                    case (fstate_q)
                        F_ON: begin
                            n_d      = n_q + 3'd1;
                            led_d    = 1'b0;
                            fstate_d = (({1'b0, n_q} + 4'd1) < {1'b0, code_q}) ? F_OFF : F_GAP;
                        end
                        F_OFF: begin
                            fstate_d = F_ON;
                            led_d    = 1'b1;
                        end
                        default: begin
                            fstate_d = F_ON;
                            n_d      = 3'd0;
                            led_d    = 1'b1;
                        end
                    endcase
                end else begin
                    led_d = ~led_q;
                end
            end
        end
    end

    always_ff @(posedge clk_input) begin
        if (!rst_n) begin
            mode_q         <= MODE_OFF;
            fstate_q       <= F_ON;
            presc_q        <= '0;
            phase_q        <= '0;
            n_q            <= 3'd0;
            code_q         <= 3'd0;
            fault_active_q <= 1'b0;
            led_q          <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            fstate_q       <= fstate_d;
            presc_q        <= presc_d;
            phase_q        <= phase_d;
            n_q            <= n_d;
            code_q         <= code_d;
            fault_active_q <= fault_active_d;
            led_q          <= led_d;
        end
    end

    assign LED          = led_q;
    assign mode         = mode_q;
    assign fault_active = fault_active_q;
endmodule
